// File: rtl/vbs_pkg.sv
// Shared definitions for the VBS video RAM bridge: FSM encoding, RAM
// geometry and the address-window decode helper.
package vbs_pkg;

    localparam int VRAM_AW = 11;
    localparam logic [4:0] DEFAULT_WINDOW_BASE = 5'b11101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_RDWAIT = 3'd2,
        ST_DONE   = 3'd3,
        ST_SKIP   = 3'd4
    } state_t;

    function automatic logic in_window(input logic [15:0] addr, input logic [4:0] base);
        return (addr[15:11] == base);
    endfunction

endpackage

// File: rtl/sync_fall_det.sv
// N-stage synchroniser for an active-low asynchronous strobe, with
// single-cycle falling- and rising-edge pulses on the synchronised level.
module sync_fall_det #(
    parameter int N = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall,
    output logic o_rise
);

    logic [N-1:0] r_sync;
    logic         r_prev;

    // Shift chain plus one-cycle history of the synchronised level; idles high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[N-2:0], i_async};
            r_prev <= r_sync[N-1];
        end
    end

    assign o_sync = r_sync[N-1];
    assign o_fall = r_prev & ~r_sync[N-1];
    assign o_rise = ~r_prev & r_sync[N-1];

endmodule

// File: rtl/z8_vram_bridge.sv
// Z8 multiplexed-bus to video RAM bridge: synchronises /AS and /DS into the
// video clock and turns each decoded bus cycle into one RAM strobe.
module z8_vram_bridge
    import vbs_pkg::*;
#(
    parameter logic [4:0] WINDOW_BASE = DEFAULT_WINDOW_BASE,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               as_n,
    input  logic               ds_n,
    input  logic               rw,
    input  logic [7:0]         a_hi,
    input  logic [7:0]         ad_in,
    output logic [7:0]         ad_out,
    output logic               ad_oe,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    output logic               vram_strobe,
    output logic               vram_write,
    input  logic [7:0]         vram_rdata
);

    logic        w_as_s, w_as_fall, w_as_rise;
    logic        w_ds_s, w_ds_fall, w_ds_rise;
    logic        w_hit;
    logic        w_unused_edges;
    logic [15:0] r_bus_q;
    logic        r_rw_q;
    logic [15:0] r_addr_q;
    state_t      r_state;

    sync_fall_det #(.N(SYNC_STAGES)) u_as_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_async (as_n),
        .o_sync  (w_as_s),
        .o_fall  (w_as_fall),
        .o_rise  (w_as_rise)
    );

    sync_fall_det #(.N(SYNC_STAGES)) u_ds_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_async (ds_n),
        .o_sync  (w_ds_s),
        .o_fall  (w_ds_fall),
        .o_rise  (w_ds_rise)
    );

    assign w_unused_edges = w_as_fall | w_as_rise | w_ds_rise;
    assign w_hit          = in_window(r_addr_q, WINDOW_BASE);

    // Bus sampling; the address keeps tracking the bus for as long as /AS is seen low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bus_q  <= 16'h0000;
            r_rw_q   <= 1'b1;
            r_addr_q <= 16'h0000;
        end else begin
            r_bus_q <= {a_hi, ad_in};
            r_rw_q  <= rw;
            if (!w_as_s) begin
                r_addr_q <= r_bus_q;
            end
        end
    end

    // Access sequencer; address and direction are frozen on entry so a late /AS cannot disturb it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            ad_out      <= 8'h00;
            ad_oe       <= 1'b0;
            vram_addr   <= {VRAM_AW{1'b0}};
            vram_wdata  <= 8'h00;
            vram_strobe <= 1'b0;
            vram_write  <= 1'b0;
        end else begin
            vram_strobe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ds_fall) begin
                        if (w_hit) begin
                            r_state     <= ST_ACCESS;
                            vram_strobe <= 1'b1;
                            vram_write  <= ~r_rw_q;
                            vram_wdata  <= r_bus_q[7:0];
                            vram_addr   <= r_addr_q[VRAM_AW-1:0];
                        end else begin
                            r_state <= ST_SKIP;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_state <= vram_write ? ST_DONE : ST_RDWAIT;
                end
                ST_RDWAIT: begin
                    ad_out  <= vram_rdata;
                    ad_oe   <= ~w_ds_s;
                    r_state <= ST_DONE;
                end
                ST_DONE, ST_SKIP: begin
                    if (w_ds_s) begin
                        ad_oe   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    ad_oe   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z8_vram_bridge.sv
// Scoreboard bench for z8_vram_bridge: bus cycles push expected RAM accesses
// and read data; a negedge monitor pops and compares them as the DUT responds.
module tb_z8_vram_bridge;
    import vbs_pkg::*;

    localparam int SYNC = 2;

    typedef struct packed {
        logic [10:0] addr;
        logic [7:0]  wdata;
        logic        wr;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        as_n = 1'b1;
    logic        ds_n = 1'b1;
    logic        rw = 1'b1;
    logic [7:0]  a_hi = 8'h00;
    logic [7:0]  ad_in = 8'h00;
    logic [7:0]  vram_rdata = 8'h00;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [10:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_strobe;
    logic        vram_write;

    acc_t        exp_acc_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  mem [0:2047];
    acc_t        mon_e;
    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          n_strobe = 0;
    int          n_oe = 0;
    int          t_ds_fall = 0;
    int          t_ds_rise = 0;
    int          t_strobe = 0;
    logic        prev_oe = 1'b0;

    z8_vram_bridge #(.WINDOW_BASE(5'b11101), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .as_n        (as_n),
        .ds_n        (ds_n),
        .rw          (rw),
        .a_hi        (a_hi),
        .ad_in       (ad_in),
        .ad_out      (ad_out),
        .ad_oe       (ad_oe),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .vram_strobe (vram_strobe),
        .vram_write  (vram_write),
        .vram_rdata  (vram_rdata)
    );

    always #125 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Video RAM model: read data valid one clock after the strobe.
    always @(posedge clk) begin
        if (vram_strobe) begin
            if (vram_write) mem[vram_addr] <= vram_wdata;
            else            vram_rdata <= mem[vram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: pop the scoreboard on every strobe and every ad_oe rise.
    always @(negedge clk) begin
        if (vram_strobe) begin
            n_strobe++;
            t_strobe = cyc;
            check("strobe_lat", cyc - t_ds_fall, SYNC + 1);
            if (exp_acc_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                mon_e = exp_acc_q.pop_front();
                check("vram_addr", {21'd0, vram_addr}, {21'd0, mon_e.addr});
                check("vram_write", {31'd0, vram_write}, {31'd0, mon_e.wr});
                if (mon_e.wr) check("vram_wdata", {24'd0, vram_wdata}, {24'd0, mon_e.wdata});
            end
        end
        if (ad_oe && !prev_oe) begin
            n_oe++;
            check("oe_lat", cyc - t_strobe, 2);
            if (exp_rd_q.size() == 0) check("unexpected_oe", 1, 0);
            else check("ad_out", {24'd0, ad_out}, {24'd0, exp_rd_q.pop_front()});
        end
        if (!ad_oe && prev_oe && reset_n) begin
            check("oe_fall_lat", cyc - t_ds_rise, SYNC + 1);
        end
        prev_oe = ad_oe;
    end

    // One complete Z8 bus cycle; for reads 'wd' is the byte expected on ad_out.
    task automatic bus_cycle(input logic [15:0] addr, input logic [7:0] wd, input logic rd,
                             input int ds_clks, input logic mid_as);
        int   s0;
        int   o0;
        logic hit;
        acc_t e;
        s0  = n_strobe;
        o0  = n_oe;
        hit = (addr[15:11] == 5'b11101);
        if (hit) begin
            e.addr  = addr[10:0];
            e.wdata = wd;
            e.wr    = ~rd;
            exp_acc_q.push_back(e);
            if (rd) exp_rd_q.push_back(wd);
        end
        @(posedge clk); #1;
        a_hi = addr[15:8]; ad_in = addr[7:0]; rw = rd; as_n = 1'b0;
        repeat (3) @(posedge clk);
        #1; as_n = 1'b1;
        repeat (SYNC + 2) @(posedge clk);
        #1; ad_in = rd ? 8'h00 : wd; ds_n = 1'b0; t_ds_fall = cyc;
        for (int i = 0; i < ds_clks; i++) begin
            @(posedge clk); #1;
            if (mid_as && i == 5) begin a_hi = 8'h00; as_n = 1'b0; end
            if (mid_as && i == 9) as_n = 1'b1;
        end
        ds_n = 1'b1; t_ds_rise = cyc;
        repeat (SYNC + 5) @(posedge clk);
        #1;
        check("strobe_count", n_strobe - s0, {31'd0, hit});
        check("oe_count", n_oe - o0, {31'd0, hit & rd});
    endtask

    initial begin
        int   s0;
        acc_t e;
        for (int i = 0; i < 2048; i++) mem[i] = i[7:0] ^ 8'hA5;
        mem[11'h7FF] = 8'hC3;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {2'b00, ad_out, ad_oe, vram_addr, vram_wdata, vram_strobe, vram_write}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        bus_cycle(16'hE805, 8'h5A, 1'b0, 8, 1'b0);
        check("mem_e805", {24'd0, mem[11'h005]}, 32'h5A);
        bus_cycle(16'hEFFF, 8'hC3, 1'b1, 8, 1'b0);
        bus_cycle(16'hE000, 8'h11, 1'b0, 8, 1'b0);
        bus_cycle(16'hF000, 8'h00, 1'b1, 8, 1'b0);
        bus_cycle(16'hE8A0, 8'h77, 1'b0, 20, 1'b1);
        bus_cycle(16'hE8A0, 8'h77, 1'b1, 20, 1'b0);
        bus_cycle(16'hE9F0, 8'h96, 1'b0, 1, 1'b0);

        // Read interrupted by reset while the bridge waits for RAM data.
        e.addr = 11'h123; e.wdata = 8'h00; e.wr = 1'b0;
        exp_acc_q.push_back(e);
        s0 = n_strobe;
        @(posedge clk); #1;
        a_hi = 8'hE9; ad_in = 8'h23; rw = 1'b1; as_n = 1'b0;
        repeat (3) @(posedge clk);
        #1; as_n = 1'b1;
        repeat (SYNC + 2) @(posedge clk);
        #1; ad_in = 8'h00; ds_n = 1'b0; t_ds_fall = cyc;
        for (int i = 0; i < 20 && n_strobe == s0; i++) @(posedge clk);
        check("rst_strobe_seen", n_strobe - s0, 1);
        #1; reset_n = 1'b0;
        #1;
        check("rst_mid_outs", {2'b00, ad_out, ad_oe, vram_addr, vram_wdata, vram_strobe, vram_write}, 32'd0);
        ds_n = 1'b1;
        repeat (3) @(posedge clk);
        #1; reset_n = 1'b1;
        repeat (2) @(posedge clk);

        bus_cycle(16'hE800, 8'h3C, 1'b0, 8, 1'b0);
        bus_cycle(16'hE800, 8'h3C, 1'b1, 8, 1'b0);

        check("acc_q_empty", exp_acc_q.size(), 0);
        check("rd_q_empty", exp_rd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
